// File: rtl/gpio_pcint.sv
// Input side of one 8-bit GPIO port: per-pin synchroniser and glitch filter,
// PIN readback, and ATmega-style pin-change flag/mask/enable with W1C clear.

module gpio_pcint_lane #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic filtered,
  output logic filtered_next
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      // Next synced value is already sitting one stage back in the chain.
      assign filtered      = synced;
      assign filtered_next = sync_q[SYNC_STAGES-2];
    end else begin : g_filt
      localparam int              CW       = $clog2(FILTER_CYCLES + 1);
      localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_CYCLES - 1);

      logic [CW-1:0] cnt, cnt_d;
      logic          filt_q, filt_d;

      always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (synced != filt_q) begin
          if (cnt == CNT_LAST) filt_d = synced;
          else                 cnt_d  = cnt + CW'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt    <= '0;
          filt_q <= 1'b0;
        end else begin
          cnt    <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign filtered      = filt_q;
      assign filtered_next = filt_d;
    end
  endgenerate

endmodule

module gpio_pcint #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_pin_in,
  input  logic             reg_sel,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [7:0]       reg_wdata,
  output logic [7:0]       reg_rdata,
  output logic             irq
);

  localparam logic [1:0] A_PIN   = 2'd0;
  localparam logic [1:0] A_PCMSK = 2'd1;
  localparam logic [1:0] A_PCIFR = 2'd2;
  localparam logic [1:0] A_PCICR = 2'd3;

  logic [WIDTH-1:0] filt, filt_next, pcmsk;
  logic             flag, en;
  logic             wr_en, rd_en, change_evt;

  gpio_pcint_lane #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_lane [WIDTH-1:0] (
    .clk           (clk),
    .rst_n         (rst_n),
    .pin           (gpio_pin_in),
    .filtered      (filt),
    .filtered_next (filt_next)
  );

  assign wr_en      = reg_sel &  reg_we;
  assign rd_en      = reg_sel & ~reg_we;
  // Uses the registered mask, so a PCMSK write only affects later cycles.
  assign change_evt = |((filt_next ^ filt) & pcmsk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcmsk <= '0;
      flag  <= 1'b0;
      en    <= 1'b0;
    end else begin
      if (wr_en && reg_addr == A_PCMSK) pcmsk <= reg_wdata[WIDTH-1:0];
      if (wr_en && reg_addr == A_PCICR) en    <= reg_wdata[0];
      // Set beats a same-cycle W1C so no edge is lost.
      if (change_evt)
        flag <= 1'b1;
      else if (wr_en && reg_addr == A_PCIFR && reg_wdata[0])
        flag <= 1'b0;
    end
  end

  always_comb begin
    reg_rdata = '0;
    if (rd_en) begin
      case (reg_addr)
        A_PIN:   reg_rdata[WIDTH-1:0] = filt;
        A_PCMSK: reg_rdata[WIDTH-1:0] = pcmsk;
        A_PCIFR: reg_rdata[0]         = flag;
        A_PCICR: reg_rdata[0]         = en;
        default: ;
      endcase
    end
  end

  assign irq = flag & en;

endmodule
